ipg_tx_mux: RTL and testbench
=============================

Name: ipg_tx_mux

Overview:
- Parametrised successor of the single-source IPG transmit path.
- Merges N independent IPG message channels into the 64b/66b encoded TX stream by overwriting idle control blocks in the inter-frame gap only. A run of MIN_IDLE idles after every frame is left untouched as a guard.
- Sits between the 64b/66b encoder output and the scrambler. One block in, one block out per cycle, fixed latency.

Parameters:
- N_CH, 4, number of IPG source channels (1..8).
- DEPTH, 8, per-channel FIFO depth in 56-bit chunks (power of 2, >=2).
- MIN_IDLE, 2, idle blocks passed unchanged after a terminate block before injection is allowed (0..15).
- IPG_BT, 8'h1e, block-type byte placed in the low byte of every injected block.
- MAX_BURST, 4, consecutive-injection limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- encoded_tx_hdr  in  2  sync header of incoming block
- encoded_tx_data  in  64  payload of incoming block; [7:0] is the block type when hdr=01
- ch_wr  in  N_CH  per-channel write strobe
- ch_data  in  56*N_CH  per-channel chunk; channel k occupies bits [56k+55:56k]
- ch_full  out  N_CH  per-channel FIFO full, registered
- ch_ovf  out  N_CH  one-cycle pulse when a write is dropped
- proced_encoded_tx_hdr  out  2  output sync header
- proced_encoded_tx_data  out  64  output payload
- tuser  out  3  {inj, ch_id[1:0]} for N_CH<=4; generally 1+clog2(N_CH) bits; inj=1 marks an injected block
- inj_count  out  32  total injected blocks, wraps modulo 2^32

Behaviour:
- Reset (async): all FIFOs empty, RR pointer = N_CH-1, FSM = GUARD, guard counter = 0, inj_count = 0. Outputs: hdr = 2'b01, data = {56'h0, 8'h1e}, tuser = 0, ch_full = 0, ch_ovf = 0. Reset mid-frame discards all FIFO contents and any partial state.
- Latency: exactly 1 cycle. The block presented at cycle t appears registered at cycle t+1, either unchanged or replaced.
- Block classification (hdr=01 only):
  - start = type in {78,33,66}
  - term = type in {87,99,aa,b4,cc,d2,e1,ff}
  - idle = type 1e
  - hdr=10 is data; hdr 00/11 are illegal.
- FSM:
  - GUARD: idle increments the guard counter; when counter+1 >= MIN_IDLE, go to OPEN. If MIN_IDLE=0, go to OPEN on the next block regardless. start goes to FRAME.
  - OPEN: start goes to FRAME. Idle is eligible for replacement.
  - FRAME: term goes to GUARD with counter cleared. All other blocks pass through.
  - Data or illegal blocks outside FRAME pass through unchanged, with no state change.
- Injection:
  - Condition: current block is idle, FSM = OPEN (evaluated before this block's own transition), and any FIFO is non-empty.
  - Replacement output: hdr = 01, data = {chunk, IPG_BT}, tuser = {1, ch}. The granted FIFO pops that cycle and inj_count increments.
  - Blocks that are not replaced output tuser = 0.
- Arbitration: round-robin. Grant goes to the first non-empty channel after the RR pointer, in ascending order with wrap. The pointer updates to the granted channel only on injection.
- FIFO rules:
  - Empty/full flags are registered. A chunk written at cycle t is eligible no earlier than cycle t+1.
  - A write while full is dropped and ch_ovf pulses, even if a pop occurs the same cycle.
  - Simultaneous write and pop on a non-full FIFO keeps the level unchanged.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: IPG_MAX_BURST_EN.
- When defined:
  - A burst counter counts consecutive injections.
  - After MAX_BURST consecutive injections, the next eligible idle is forced through unreplaced and the counter clears.
  - Any non-injected block also clears the counter.
- When undefined: every eligible idle is replaced while data is pending; no burst counter is synthesised.

Test Plan:
- Reset, ch0 writes 56'hA5 once, stream = 6 idles with MIN_IDLE=2 -> first idle out unchanged; 2nd (FSM reaches OPEN, not yet eligible) unchanged; 3rd out = {56'hA5,8'h1e} with tuser = {1,0}; inj_count = 1.
- Chunk pending; stream = start, 5 data, term_3, idle, idle, idle -> nothing replaced before the 3rd idle; the 3rd idle after term is replaced.
- ch0, ch2, ch3 each hold 2 chunks; 10 idles in OPEN -> grant order 0,2,3,0,2,3, then 4 unchanged idles.
- ch1 written DEPTH+1 times with no idles -> ch_full = 1 after DEPTH writes; ch_ovf pulses once; exactly DEPTH chunks injected later, in order.
- Assert reset during an injection burst -> next cycle outputs idle, tuser = 0, ch_full = 0; FIFOs empty afterwards.
- With IPG_MAX_BURST_EN, MAX_BURST=4, 10 chunks pending, 12 idles in OPEN -> pattern of 4 injected, 1 idle, 4 injected, 1 idle, 2 injected.

Source files
------------

// File: rtl/ipg_tx_mux.sv
// ipg_tx_mux: merges N_CH IPG message FIFOs into idle blocks of the 64b/66b TX inter-frame gap.
// Optional macro IPG_MAX_BURST_EN caps consecutive injections at MAX_BURST.
module ipg_tx_mux #(
  parameter int         N_CH      = 4,
  parameter int         DEPTH     = 8,
  parameter int         MIN_IDLE  = 2,
  parameter logic [7:0] IPG_BT    = 8'h1e,
  parameter int         MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            encoded_tx_hdr,
  input  logic [63:0]           encoded_tx_data,
  input  logic [N_CH-1:0]       ch_wr,
  input  logic [56*N_CH-1:0]    ch_data,
  output logic [N_CH-1:0]       ch_full,
  output logic [N_CH-1:0]       ch_ovf,
  output logic [1:0]            proced_encoded_tx_hdr,
  output logic [63:0]           proced_encoded_tx_data,
  output logic [$clog2(N_CH):0] tuser,
  output logic [31:0]           inj_count
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TU_W  = $clog2(N_CH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (N_CH < 1 || N_CH > 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      MIN_IDLE < 0 || MIN_IDLE > 15 || MAX_BURST < 1) begin : g_param_check
    $error("ipg_tx_mux: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_GUARD,
    ST_OPEN,
    ST_FRAME
  } state_t;

  function automatic logic is_start_type(input logic [7:0] t);
    return (t == 8'h78) || (t == 8'h33) || (t == 8'h66);
  endfunction

  function automatic logic is_term_type(input logic [7:0] t);
    case (t)
      8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic             blk_ctl, blk_idle, blk_start, blk_term;
  logic [55:0]      mem [N_CH][DEPTH];
  logic [PTR_W-1:0] wr_ptr [N_CH];
  logic [PTR_W-1:0] rd_ptr [N_CH];
  logic [LVL_W-1:0] level [N_CH];
  logic [LVL_W-1:0] lvl_nxt [N_CH];
  logic [N_CH-1:0]  full_q, empty_q, wr_ok, pop_vec, ovf_q;
  logic [CH_W-1:0]  rr_ptr, grant_ch, scan_ch;
  logic             grant_vld, burst_hold, inj_en;
  logic [TU_W-1:0]  tuser_inj;
  logic [55:0]      rd_chunk;
  state_t           state;
  logic [3:0]       guard_cnt;
  logic [1:0]       hdr_p1;
  logic [63:0]      data_p1;
  logic [TU_W-1:0]  tuser_p1;
  logic [31:0]      inj_cnt_q;

  assign blk_ctl   = (encoded_tx_hdr == 2'b01);
  assign blk_idle  = blk_ctl && (encoded_tx_data[7:0] == 8'h1e);
  assign blk_start = blk_ctl && is_start_type(encoded_tx_data[7:0]);
  assign blk_term  = blk_ctl && is_term_type(encoded_tx_data[7:0]);

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    scan_ch   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      scan_ch = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (!grant_vld && !empty_q[scan_ch]) begin
        grant_vld = 1'b1;
        grant_ch  = scan_ch;
      end
    end
  end

`ifdef IPG_MAX_BURST_EN
  localparam int BC_W = $clog2(MAX_BURST + 1);
  logic [BC_W-1:0] burst_cnt;

  // A held-off idle is itself a non-injected block, so the counter clears there too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (inj_en) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else begin
      burst_cnt <= '0;
    end
  end

  assign burst_hold = (burst_cnt == BC_W'(MAX_BURST));
`else
  assign burst_hold = 1'b0;
`endif

  assign inj_en   = blk_idle && (state == ST_OPEN) && grant_vld && !burst_hold;
  assign wr_ok    = ch_wr & ~full_q;
  assign rd_chunk = mem[grant_ch][rd_ptr[grant_ch]];

  always_comb begin
    pop_vec = '0;
    if (inj_en) pop_vec[grant_ch] = 1'b1;
    tuser_inj = TU_W'(grant_ch);
    tuser_inj[TU_W-1] = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      lvl_nxt[k] = level[k] + LVL_W'(wr_ok[k]) - LVL_W'(pop_vec[k]);
    end
  end

  // FIFO storage carries no reset; validity lives entirely in the pointers and level.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (wr_ok[k]) mem[k][wr_ptr[k]] <= ch_data[56*k +: 56];
    end
  end

  // Full is the registered flag, so a write while full drops even when a pop lands that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        level[k]  <= '0;
      end
      full_q  <= '0;
      empty_q <= '1;
      ovf_q   <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_ok[k])   wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop_vec[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        level[k]   <= lvl_nxt[k];
        full_q[k]  <= (lvl_nxt[k] == LVL_W'(DEPTH));
        empty_q[k] <= (lvl_nxt[k] == '0);
      end
      ovf_q <= ch_wr & full_q;
    end
  end

  // Stage p0 -> p1: gap tracking and the single registered output block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_GUARD;
      guard_cnt <= '0;
      rr_ptr    <= CH_W'(N_CH - 1);
      inj_cnt_q <= '0;
      hdr_p1    <= 2'b01;
      data_p1   <= {56'h0, 8'h1e};
      tuser_p1  <= '0;
    end else begin
      case (state)
        ST_GUARD: begin
          if (blk_start) begin
            state <= ST_FRAME;
          end else if (MIN_IDLE == 0) begin
            if (blk_ctl) state <= ST_OPEN;
          end else if (blk_idle) begin
            guard_cnt <= guard_cnt + 1'b1;
            if (({1'b0, guard_cnt} + 5'd1) >= 5'(MIN_IDLE)) state <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (blk_start) state <= ST_FRAME;
        end
        ST_FRAME: begin
          if (blk_term) begin
            state     <= ST_GUARD;
            guard_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_GUARD;
          guard_cnt <= '0;
        end
      endcase

      if (inj_en) begin
        hdr_p1    <= 2'b01;
        data_p1   <= {rd_chunk, IPG_BT};
        tuser_p1  <= tuser_inj;
        rr_ptr    <= grant_ch;
        inj_cnt_q <= inj_cnt_q + 32'd1;
      end else begin
        hdr_p1   <= encoded_tx_hdr;
        data_p1  <= encoded_tx_data;
        tuser_p1 <= '0;
      end
    end
  end

  assign proced_encoded_tx_hdr  = hdr_p1;
  assign proced_encoded_tx_data = data_p1;
  assign tuser                  = tuser_p1;
  assign inj_count              = inj_cnt_q;
  assign ch_full                = full_q;
  assign ch_ovf                 = ovf_q;

endmodule

// File: tb/tb_ipg_tx_mux.sv
// Bench for ipg_tx_mux: queue-based gap/arbitration model checked every cycle, plus literal pins.
module tb_ipg_tx_mux;
  localparam int         N_CH      = 4;
  localparam int         DEPTH     = 8;
  localparam int         MIN_IDLE  = 2;
  localparam int         MAX_BURST = 4;
  localparam logic [7:0] IPG_BT    = 8'h1e;
  localparam int         TU_W      = 3;
  localparam logic [63:0] IDLE_BLK = 64'h1e;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           hdr_i;
  logic [63:0]          data_i;
  logic [N_CH-1:0]      wr_i;
  logic [56*N_CH-1:0]   wdata_i;
  logic [N_CH-1:0]      ch_full, ch_ovf;
  logic [1:0]           o_hdr;
  logic [63:0]          o_data;
  logic [TU_W-1:0]      tuser;
  logic [31:0]          inj_count;

  always #5 clk = ~clk;

  ipg_tx_mux #(
    .N_CH(N_CH), .DEPTH(DEPTH), .MIN_IDLE(MIN_IDLE), .IPG_BT(IPG_BT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .encoded_tx_hdr(hdr_i), .encoded_tx_data(data_i),
    .ch_wr(wr_i), .ch_data(wdata_i),
    .ch_full(ch_full), .ch_ovf(ch_ovf),
    .proced_encoded_tx_hdr(o_hdr), .proced_encoded_tx_data(o_data),
    .tuser(tuser), .inj_count(inj_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: per-channel queues, "in frame" flag and idles seen in the current gap.
  logic [55:0]     mq [N_CH][$];
  int              m_rr, m_gap, m_burst;
  bit              m_frame;
  logic [31:0]     m_inj;
  logic [1:0]      e_hdr;
  logic [63:0]     e_data;
  logic [TU_W-1:0] e_tuser;
  logic [N_CH-1:0] e_full, e_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) mq[k].delete();
    m_rr = N_CH - 1; m_gap = 0; m_burst = 0; m_frame = 1'b0; m_inj = '0;
    e_hdr = 2'b01; e_data = IDLE_BLK; e_tuser = '0; e_full = '0; e_ovf = '0;
  endtask

  task automatic model_step(input logic [1:0] h, input logic [63:0] d,
                            input logic [N_CH-1:0] w, input logic [56*N_CH-1:0] wd);
    logic [7:0] t;
    bit ctl, idle, start, term, elig;
    bit full_before [N_CH];
    int g;
    t = d[7:0];
    ctl   = (h == 2'b01);
    idle  = ctl && (t == 8'h1e);
    start = ctl && (t inside {8'h78, 8'h33, 8'h66});
    term  = ctl && (t inside {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff});
    for (int k = 0; k < N_CH; k++) full_before[k] = (mq[k].size() == DEPTH);
    g = -1;
    for (int i = 1; i <= N_CH; i++) begin
      if (g < 0 && mq[(m_rr + i) % N_CH].size() > 0) g = (m_rr + i) % N_CH;
    end
    elig = idle && !m_frame && (m_gap >= MIN_IDLE) && (g >= 0);
`ifdef IPG_MAX_BURST_EN
    if (elig && m_burst == MAX_BURST) elig = 1'b0;
`endif
    e_hdr = h; e_data = d; e_tuser = '0;
    if (elig) begin
      e_hdr   = 2'b01;
      e_data  = {mq[g].pop_front(), IPG_BT};
      e_tuser = {1'b1, 2'(g)};
      m_rr    = g;
      m_inj   = m_inj + 1;
      m_burst = m_burst + 1;
    end else begin
      m_burst = 0;
    end
    if (!m_frame && start) m_frame = 1'b1;
    else if (m_frame && term) begin m_frame = 1'b0; m_gap = 0; end
    else if (!m_frame && idle && m_gap < MIN_IDLE) m_gap = m_gap + 1;
    for (int k = 0; k < N_CH; k++) begin
      e_ovf[k] = w[k] && full_before[k];
      if (w[k] && !full_before[k]) mq[k].push_back(wd[56*k +: 56]);
      e_full[k] = (mq[k].size() == DEPTH);
    end
  endtask

  task automatic step(input logic [1:0] h, input logic [63:0] d,
                      input logic [N_CH-1:0] w, input logic [56*N_CH-1:0] wd);
    hdr_i = h; data_i = d; wr_i = w; wdata_i = wd;
    model_step(h, d, w, wd);
    @(posedge clk); #1;
    chk("hdr", 64'(o_hdr), 64'(e_hdr));
    chk("data", o_data, e_data);
    chk("tuser", 64'(tuser), 64'(e_tuser));
    chk("ch_full", 64'(ch_full), 64'(e_full));
    chk("ch_ovf", 64'(ch_ovf), 64'(e_ovf));
    chk("inj_count", 64'(inj_count), 64'(m_inj));
  endtask

  task automatic idle_blk();
    step(2'b01, IDLE_BLK, '0, '0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hdr"}, 64'(o_hdr), 64'(2'b01));
    chk({tag, "_data"}, o_data, IDLE_BLK);
    chk({tag, "_tuser"}, 64'(tuser), 64'h0);
    chk({tag, "_full"}, 64'(ch_full), 64'h0);
    chk({tag, "_ovf"}, 64'(ch_ovf), 64'h0);
    chk({tag, "_inj"}, 64'(inj_count), 64'h0);
  endtask

  task automatic do_reset();
    hdr_i = 2'b01; data_i = IDLE_BLK; wr_i = '0; wdata_i = '0;
    reset = 1'b1;
    #2;
    chk_reset_outs("rst");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [56*N_CH-1:0] chunks(input logic [55:0] c0, input logic [55:0] c1,
                                               input logic [55:0] c2, input logic [55:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  exp_tu [10];
    logic [55:0] exp_ck [6];
    logic [11:0] pat;

    reset = 1'b1; hdr_i = 2'b01; data_i = IDLE_BLK; wr_i = '0; wdata_i = '0;
    #2;
    chk_reset_outs("por");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Single chunk, guard of two idles, third idle replaced.
    do_reset();
    step(2'b01, IDLE_BLK, 4'b0001, chunks(56'hA5, 56'h0, 56'h0, 56'h0));
    chk("t1_idle1", o_data, IDLE_BLK);
    idle_blk();
    chk("t1_idle2", o_data, IDLE_BLK);
    idle_blk();
    chk("t1_inj_data", o_data, {56'hA5, 8'h1e});
    chk("t1_inj_tuser", 64'(tuser), 64'(3'b100));
    chk("t1_inj_count", 64'(inj_count), 64'd1);
    for (int i = 0; i < 3; i++) idle_blk();
    chk("t1_after", 64'(tuser), 64'h0);

    // Frame then gap: only the third idle after the terminate is replaced.
    do_reset();
    step(2'b01, 64'h0000_0000_0000_0078, 4'b0001, chunks(56'hBEEF, 56'h0, 56'h0, 56'h0));
    for (int i = 0; i < 5; i++) step(2'b10, 64'h0123_4567_89ab_cdef + 64'(i), '0, '0);
    step(2'b01, 64'h0000_0000_0000_00b4, '0, '0);
    idle_blk();
    chk("t2_idle1", o_data, IDLE_BLK);
    idle_blk();
    chk("t2_idle2", o_data, IDLE_BLK);
    idle_blk();
    chk("t2_idle3", o_data, {56'hBEEF, 8'h1e});

    // Round-robin over ch0, ch2, ch3 with two chunks each.
    do_reset();
    step(2'b01, IDLE_BLK, 4'b1101, chunks(56'h10, 56'h0, 56'h12, 56'h13));
    step(2'b01, IDLE_BLK, 4'b1101, chunks(56'h20, 56'h0, 56'h22, 56'h23));
    exp_tu = '{3'b100, 3'b110, 3'b111, 3'b100, 3'b110, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_ck = '{56'h10, 56'h12, 56'h13, 56'h20, 56'h22, 56'h23};
    for (int i = 0; i < 10; i++) begin
      idle_blk();
      chk($sformatf("t3_tuser%0d", i), 64'(tuser), 64'(exp_tu[i]));
      if (i < 6) chk($sformatf("t3_data%0d", i), o_data, {exp_ck[i], 8'h1e});
    end

    // Overflow of ch1: DEPTH+1 writes while data blocks flow.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      step(2'b10, 64'hDA7A_0000 + 64'(i), 4'b0010, chunks(56'h0, 56'h1000 + 56'(i), 56'h0, 56'h0));
      if (i == DEPTH - 1) chk("t4_full", 64'(ch_full), 64'(4'b0010));
      if (i == DEPTH)     chk("t4_ovf", 64'(ch_ovf), 64'(4'b0010));
    end
    step(2'b10, 64'hDA7A_FFFF, '0, '0);
    chk("t4_ovf_clear", 64'(ch_ovf), 64'h0);
    idle_blk();
    idle_blk();
    for (int i = 0; i < DEPTH; i++) begin
      idle_blk();
      chk($sformatf("t4_chunk%0d", i), o_data, {56'h1000 + 56'(i), 8'h1e});
    end
    idle_blk();
    chk("t4_drained", 64'(tuser), 64'h0);
    chk("t4_count", 64'(inj_count), 64'(DEPTH));

    // Reset in the middle of an injection burst.
    do_reset();
    for (int i = 0; i < 5; i++)
      step(2'b10, 64'h5555_0000 + 64'(i), 4'b0001, chunks(56'h500 + 56'(i), 56'h0, 56'h0, 56'h0));
    idle_blk();
    idle_blk();
    idle_blk();
    idle_blk();
    chk("t5_pre_inj", 64'(tuser), 64'(3'b100));
    reset = 1'b1;
    #2;
    chk_reset_outs("t5_mid");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle_blk();
    chk("t5_empty", 64'(tuser), 64'h0);
    chk("t5_count", 64'(inj_count), 64'h0);

    // Ten chunks over 12 open idles; burst cap changes the pattern when enabled.
    do_reset();
    for (int i = 0; i < 5; i++)
      step(2'b10, 64'h6666_0000 + 64'(i), 4'b0011,
           chunks(56'h600 + 56'(i), 56'h700 + 56'(i), 56'h0, 56'h0));
    idle_blk();
    idle_blk();
`ifdef IPG_MAX_BURST_EN
    pat = 12'b1101_1110_1111;
`else
    pat = 12'b0011_1111_1111;
`endif
    for (int i = 0; i < 12; i++) begin
      idle_blk();
      chk($sformatf("t6_inj%0d", i), 64'(tuser[2]), 64'(pat[i]));
    end
    chk("t6_count", 64'(inj_count), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
